stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the 16-bit, 4-digit BCD counter, which is run as a 0000–9999 stopwatch. It turns single-cycle start/stop/lap/clear command pulses into a divided count-enable pulse train and a clear pulse for the counter. It stops at 9999 instead of wrapping, and provides a lap-freezable copy of the count for the display path. It sits between the debounced button logic and the counter/7-segment driver.

## Interface
- TICK_DIV, 100000, clk_i cycles per count increment; must be ≥ 2
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  start/resume command, single-cycle pulse
- stop_i  in  1  pause command, single-cycle pulse
- lap_i  in  1  lap freeze/unfreeze toggle, single-cycle pulse
- clear_i  in  1  clear-to-zero command, single-cycle pulse
- cnt_i  in  16  current BCD count from the counter
- cnt_en_o  out  1  counter enable; one-cycle pulse per tick
- cnt_rst_o  out  1  counter clear; registered and glitch-free
- disp_o  out  16  BCD value for the display
- state_o  out  2  FSM state encoding
- ovf_o  out  1  sticky flag: count reached 9999 and is held

## Operation
- States and encodings: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Command priority when several commands arrive in one cycle: clear_i > stop_i > start_i > lap_i. Only the highest-priority valid command acts.
- clear_i, from any state:
  - Go to IDLE.
  - Pulse cnt_rst_o for 1 cycle.
  - Zero the prescaler.
  - Clear the freeze flag and ovf_o.
  - Force cnt_en_o to 0.
- start_i:
  - IDLE→RUN, with the prescaler zeroed.
  - PAUSE→RUN, with the prescaler value retained.
  - Ignored in RUN and DONE.
- stop_i: RUN→PAUSE; the prescaler holds its value. Ignored in other states.
- lap_i: in RUN or PAUSE, toggles the freeze flag. On the 0→1 toggle, disp_o captures cnt_i. Ignored in IDLE and DONE.
- Prescaler (RUN only):
  - p increments each cycle.
  - When p==TICK_DIV-1, p←0 and one of two things happens:
    - If cnt_i!=16'h9999, cnt_en_o←1 for the next cycle.
    - If cnt_i==16'h9999, go to DONE, set ovf_o←1, and do not pulse cnt_en_o.
- DONE:
  - The counter stays at 9999.
  - The freeze flag is cleared.
  - Only clear_i leaves DONE.
- disp_o:
  - Freeze flag=0: registered copy of cnt_i, 1-cycle latency.
  - Freeze flag=1: holds the captured value while the counter keeps running.
- A stop_i arriving in the same cycle cnt_en_o is high does not cancel that pulse; the counter still increments once.

## Timing
- Reset values:
  - state_o=IDLE
  - cnt_en_o=0
  - cnt_rst_o=1; drops to 0 at the first clk_i edge after rst_i deasserts
  - disp_o=0
  - ovf_o=0
  - p=0
  - freeze=0
- Tick timing: start_i is sampled at edge E0. cnt_en_o is high between E(TICK_DIV) and E(TICK_DIV+1), and the counter increments at E(TICK_DIV+1). After that, one increment every TICK_DIV cycles with no drift.
- The overflow check at p==TICK_DIV-1 always sees cnt_i already updated by the previous pulse. This is guaranteed because TICK_DIV ≥ 2.
- Command-to-output latency is 1 cycle for:
  - clear_i→cnt_rst_o
  - command→state_o
  - lap_i→disp_o capture
- Asserting rst_i mid-operation asynchronously forces all reset values. Any in-flight tick is lost.

## Structure
- Package stopwatch_pkg holds:
  - the state encodings
  - BCD_MAX = 16'h9999
  - the $clog2(TICK_DIV) width helper
- Sub-module tick_prescaler contains:
  - the divide-by-TICK_DIV counter
  - inputs run_i (count) and zero_i (clear)
  - output tc_o (terminal count)
- The FSM, freeze latch and overflow logic stay in stopwatch_ctrl.

## Test plan
All scenarios use TICK_DIV=4.
- Reset release, then start_i at E0 → cnt_en_o high only during E4–E5; cnt_i=0001 after E5, 0002 after E9.
- Run to 0012, stop_i, wait 20 cycles, start_i → count stays at 0012 while PAUSE; increments resume with the retained prescaler phase, and the next increment comes ≤4 cycles after start_i.
- At count 0005, lap_i → disp_o holds 0005 while cnt_i advances to 0008; second lap_i → disp_o tracks cnt_i one cycle later.
- Preload the counter to 9998 and run → 9999 reached; at the next terminal count, state_o=DONE, ovf_o=1, no cnt_en_o pulse, count stays at 9999; start_i has no effect.
- clear_i, stop_i and start_i in the same cycle during RUN → IDLE, cnt_rst_o pulses 1 cycle, counter reads 0000, ovf_o=0.
- rst_i asserted mid-RUN with cnt_en_o high → all outputs take their reset values immediately; cnt_rst_o=1 until the first edge after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control path: FSM state encodings,
// the BCD ceiling of the 4-digit counter and the prescaler width helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Bits needed to hold 0..div-1; never less than one bit.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Divide-by-TICK_DIV phase counter. Counts while run_i is high, holds its
// phase otherwise, and is forced to zero by zero_i. tc_o flags the cycle in
// which the counter sits at TICK_DIV-1 and is allowed to advance.
module tick_prescaler
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000
)
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic zero_i,
    output logic tc_o
);

    localparam int unsigned    W    = presc_width(TICK_DIV);
    localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

    logic [W-1:0] p;

    assign tc_o = run_i && (p == LAST);

    // Phase counter: clear has priority, then wrap at LAST, else hold.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p <= '0;
        end else if (zero_i) begin
            p <= '0;
        end else if (run_i) begin
            if (p == LAST)
                p <= '0;
            else
                p <= p + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: turns start/stop/lap/clear pulses into a count-enable
// pulse train and a clear pulse for the external BCD counter, stops at 9999
// and keeps a lap-freezable copy of the count for the display.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        lap_i,
    input  logic        clear_i,
    input  logic [15:0] cnt_i,
    output logic        cnt_en_o,
    output logic        cnt_rst_o,
    output logic [15:0] disp_o,
    output logic [1:0]  state_o,
    output logic        ovf_o
);

    state_t state;
    logic   freeze;
    logic   freeze_nx;

    // Decoded commands: each is high only when it is the acting command.
    logic clr;
    logic stp;
    logic sta;
    logic lapv;

    logic zero;
    logic run;
    logic tc;
    logic at_max;

    // Command arbitration: clear > stop > start > lap, with a command that
    // does not apply in the current state dropping out of the arbitration.
    always_comb begin
        clr  = clear_i;
        stp  = 1'b0;
        sta  = 1'b0;
        lapv = 1'b0;
        if (!clear_i) begin
            case (state)
                IDLE: begin
                    sta = start_i;
                end
                RUN: begin
                    stp  = stop_i;
                    lapv = lap_i && !stop_i;
                end
                PAUSE: begin
                    sta  = start_i;
                    lapv = lap_i && !start_i;
                end
                default: begin
                end
            endcase
        end
    end

    // A stop in RUN freezes the phase in the same cycle, so run excludes it.
    assign zero   = clr || (sta && (state == IDLE));
    assign run    = (state == RUN) && !clr && !stp;
    assign at_max = (cnt_i == BCD_MAX);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .run_i  (run),
        .zero_i (zero),
        .tc_o   (tc)
    );

    // Next value of the lap freeze flag.
    always_comb begin
        freeze_nx = freeze;
        if (clr)
            freeze_nx = 1'b0;
        else if (state == DONE)
            freeze_nx = 1'b0;
        else if (tc && at_max)
            freeze_nx = 1'b0;
        else if (lapv)
            freeze_nx = ~freeze;
    end

    // FSM with registered counter controls, overflow flag and display copy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            freeze    <= 1'b0;
            cnt_en_o  <= 1'b0;
            cnt_rst_o <= 1'b1;
            disp_o    <= '0;
            ovf_o     <= 1'b0;
        end else begin
            cnt_en_o  <= 1'b0;
            cnt_rst_o <= clr;
            freeze    <= freeze_nx;

            // Display holds only while the flag stays set across this edge;
            // the capturing edge and the releasing edge both load cnt_i.
            if (!(freeze && freeze_nx))
                disp_o <= cnt_i;

            if (clr) begin
                state <= IDLE;
                ovf_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (sta)
                            state <= RUN;
                    end
                    RUN: begin
                        if (stp) begin
                            state <= PAUSE;
                        end else if (tc) begin
                            if (at_max) begin
                                state <= DONE;
                                ovf_o <= 1'b1;
                            end else begin
                                cnt_en_o <= 1'b1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (sta)
                            state <= RUN;
                    end
                    DONE: begin
                        state <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4. A BCD counter
// model sits on the cnt_* ports; a behavioural model predicts every cycle's
// outputs into a queue that a separate monitor drains and compares.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic        rst;
        logic        ovf;
        logic [15:0] disp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] cnt = 16'h0000;
    logic        cnt_en;
    logic        cnt_rst;
    logic [15:0] disp;
    logic [1:0]  state;
    logic        ovf;

    logic        load_req = 1'b0;
    logic [15:0] load_val = 16'h0000;

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    exp_t last_exp;

    // Behavioural model state
    int          m_mode = M_IDLE;
    int          m_phase = 0;
    bit          m_frozen = 1'b0;
    bit          m_ovf = 1'b0;
    logic [15:0] m_disp = 16'h0000;

    stopwatch_ctrl #(.TICK_DIV(DIV)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .stop_i    (stop),
        .lap_i     (lap),
        .clear_i   (clear),
        .cnt_i     (cnt),
        .cnt_en_o  (cnt_en),
        .cnt_rst_o (cnt_rst),
        .disp_o    (disp),
        .state_o   (state),
        .ovf_o     (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        int n;
        n = v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
        n = (n + 1) % 10000;
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // External 4-digit BCD counter driven by the DUT controls.
    always @(posedge clk) begin
        if (load_req)
            cnt <= load_val;
        else if (cnt_rst)
            cnt <= 16'h0000;
        else if (cnt_en)
            cnt <= bcd_inc(cnt);
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_phase  = 0;
        m_frozen = 1'b0;
        m_ovf    = 1'b0;
        m_disp   = 16'h0000;
    endtask

    // Drive one cycle of commands (at a falling edge), predict the outputs
    // after the coming rising edge, queue them, and advance to the next fall.
    task automatic step(input bit c, input bit s, input bit g, input bit l);
        exp_t e;
        bit   was_frozen;
        clear = c;
        stop  = s;
        start = g;
        lap   = l;
        was_frozen = m_frozen;
        e.en  = 1'b0;
        e.rst = c;
        if (c) begin
            m_mode   = M_IDLE;
            m_phase  = 0;
            m_frozen = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (g) begin
                        m_mode  = M_RUN;
                        m_phase = 0;
                    end
                end
                M_RUN: begin
                    if (s) begin
                        m_mode = M_PAUSE;
                    end else begin
                        if (l)
                            m_frozen = !m_frozen;
                        m_phase++;
                        if (m_phase == DIV) begin
                            m_phase = 0;
                            if (cnt == 16'h9999) begin
                                m_mode   = M_DONE;
                                m_ovf    = 1'b1;
                                m_frozen = 1'b0;
                            end else begin
                                e.en = 1'b1;
                            end
                        end
                    end
                end
                M_PAUSE: begin
                    if (g)
                        m_mode = M_RUN;
                    else if (l)
                        m_frozen = !m_frozen;
                end
                default: begin
                end
            endcase
        end
        if (!(was_frozen && m_frozen))
            m_disp = cnt;
        e.st   = 2'(m_mode);
        e.ovf  = m_ovf;
        e.disp = m_disp;
        q.push_back(e);
        last_exp = e;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0);
    endtask

    task automatic run_until(input logic [15:0] target, input int budget, input string name);
        int n;
        n = 0;
        while (cnt !== target && n < budget) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk(name, cnt, target);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, 16'(state), 16'h0);
        chk({tag, "_en"}, 16'(cnt_en), 16'h0);
        chk({tag, "_rst"}, 16'(cnt_rst), 16'h1);
        chk({tag, "_disp"}, disp, 16'h0000);
        chk({tag, "_ovf"}, 16'(ovf), 16'h0);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_state", 16'(state), 16'(e.st));
                chk("sb_cnt_en", 16'(cnt_en), 16'(e.en));
                chk("sb_cnt_rst", 16'(cnt_rst), 16'(e.rst));
                chk("sb_ovf", 16'(ovf), 16'(e.ovf));
                chk("sb_disp", disp, e.disp);
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2ms;
        errors++;
        $display("FAIL watchdog: simulation time limit expired");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [15:0] prev;
        bit          c, s, g, l;

        // Power-on reset
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_values("por");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("por_rst_hold", 16'(cnt_rst), 16'h1);
        step(0, 0, 0, 0);

        // First ticks after start
        step(0, 0, 1, 0);
        idle(4);
        chk("tick1_before", cnt, 16'h0000);
        idle(1);
        chk("tick1_after", cnt, 16'h0001);
        idle(4);
        chk("tick2_after", cnt, 16'h0002);

        // Pause and resume with retained phase
        run_until(16'h0012, 200, "reach_0012");
        step(0, 1, 0, 0);
        idle(20);
        chk("paused_hold", cnt, 16'h0012);
        step(0, 0, 1, 0);
        n = 0;
        while (cnt == 16'h0012 && n < 6) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("resume_cnt", cnt, 16'h0013);
        chk("resume_latency_ok", 16'(n <= 5), 16'h1);

        // Lap freeze and release
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        run_until(16'h0005, 40, "reach_0005");
        step(0, 0, 0, 1);
        run_until(16'h0008, 40, "reach_0008");
        chk("lap_frozen", disp, 16'h0005);
        step(0, 0, 0, 1);
        prev = cnt;
        step(0, 0, 0, 0);
        chk("lap_tracking", disp, prev);

        // Saturation at 9999
        step(1, 0, 0, 0);
        load_req = 1'b1;
        load_val = 16'h9998;
        step(0, 0, 0, 0);
        load_req = 1'b0;
        chk("preload", cnt, 16'h9998);
        step(0, 0, 1, 0);
        run_until(16'h9999, 20, "reach_9999");
        n = 0;
        while (m_mode != M_DONE && n < 10) begin
            step(0, 0, 0, 0);
            n++;
        end
        step(0, 0, 0, 0);
        chk("done_state", 16'(state), 16'h3);
        chk("done_ovf", 16'(ovf), 16'h1);
        chk("done_cnt", cnt, 16'h9999);
        step(0, 0, 1, 0);
        idle(6);
        chk("done_start_ignored", 16'(state), 16'h3);
        chk("done_cnt_held", cnt, 16'h9999);

        // Simultaneous clear/stop/start in RUN
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        run_until(16'h0003, 30, "reach_0003");
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        chk("multi_cnt", cnt, 16'h0000);
        chk("multi_state", 16'(state), 16'h0);
        chk("multi_ovf", 16'(ovf), 16'h0);

        // Asynchronous reset while cnt_en_o is high
        step(0, 0, 1, 0);
        n = 0;
        do begin
            step(0, 0, 0, 0);
            n++;
        end while (!last_exp.en && n < 10);
        chk("pre_reset_en", 16'(cnt_en), 16'h1);
        rst = 1'b1;
        #1;
        chk_reset_values("mid");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("tick_lost", cnt, 16'h0000);
        rst = 1'b0;
        #1;
        chk("mid_rst_hold", 16'(cnt_rst), 16'h1);
        step(0, 0, 0, 0);

        // Randomized command traffic
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 11) == 0);
            g = ($urandom_range(0, 7) == 0);
            l = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 79) == 0) begin
                load_req = 1'b1;
                load_val = 16'h9997;
            end
            step(c, s, g, l);
            load_req = 1'b0;
        end
        idle(2);

        n = 0;
        while (q.size() != 0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 16'(q.size()), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
